// File: rtl/uart_msg_streamer.sv
// Streams a fixed message out of a UART transmitter, optionally repeating it
// after an idle gap. The line is driven from a register so it never glitches.
module uart_msg_streamer #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD_RATE = 115200,
    parameter int MSG_LEN = 15,
    parameter logic [MSG_LEN*8-1:0] MSG = "Hello, world!\r\n",
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int GAP_CYCLES = 5000000,
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             periodic_en,
    input  logic             abort,
    output logic             uart_tx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] byte_idx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW = $clog2(BAUD_DIV);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

    state_t           state, state_d;
    logic [BW-1:0]    baud_cnt, baud_d;
    logic [2:0]       bit_cnt, bit_d;
    logic [IDX_W-1:0] idx_d;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic             abort_q, abort_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic [7:0]       cur_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            abort_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            byte_idx <= idx_d;
            gap_cnt  <= gap_d;
            abort_q  <= abort_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt + BW'(1);
        bit_d   = bit_cnt;
        idx_d   = byte_idx;
        gap_d   = gap_cnt;
        done    = 1'b0;
        bit_end = (baud_cnt == BAUD_LAST);
        case (state)
            IDLE: begin
                baud_d = '0;
                if (start) begin
                    state_d = START;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_d = '0;
                        // A pending abort wins over both the next byte and the done pulse.
                        if (abort_q || abort) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else if (byte_idx == IDX_LAST) begin
                            done    = 1'b1;
                            idx_d   = '0;
                            gap_d   = '0;
                            state_d = periodic_en ? GAP : IDLE;
                        end else begin
                            state_d = START;
                            idx_d   = byte_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end
            end
            GAP: begin
                baud_d = '0;
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_d = START;
                end else begin
                    gap_d = gap_cnt + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        abort_d = (state_d != IDLE) && (abort_q || (abort && state != IDLE));

        cur_byte = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx_d == IDX_W'(i)) cur_byte = MSG[(MSG_LEN-1-i)*8 +: 8];
        end

        // Line value is computed for the upcoming cycle so the register holds it.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            PAR:     tx_d = (PARITY == 2) ? ^cur_byte : ~^cur_byte;
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx = tx_q;
    assign busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_msg_streamer.sv
// Randomized bench for uart_msg_streamer: five configurations share one clock and
// each run is compared cycle by cycle against a line-level reference model.
module tb_uart_msg_streamer;
    localparam int BAUD_DIV = 10;
    localparam int GAP = 50;

    logic       clk;
    logic [4:0] rst, start, per, abort;
    logic [4:0] tx, busy, done, idx;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] full_q[$];
    int         end_q[$];

    // 0: "AB" no parity 1 stop, 1: "A" even, 2: "A" odd, 3: "AB" 2 stops, 4: "A" plain
    uart_msg_streamer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSG_LEN(2), .MSG("AB"),
        .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(GAP)) u0 (.clk(clk), .rst(rst[0]),
        .start(start[0]), .periodic_en(per[0]), .abort(abort[0]), .uart_tx(tx[0]),
        .busy(busy[0]), .done(done[0]), .byte_idx(idx[0]));
    uart_msg_streamer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSG_LEN(1), .MSG("A"),
        .PARITY(2), .STOP_BITS(1), .GAP_CYCLES(GAP)) u1 (.clk(clk), .rst(rst[1]),
        .start(start[1]), .periodic_en(per[1]), .abort(abort[1]), .uart_tx(tx[1]),
        .busy(busy[1]), .done(done[1]), .byte_idx(idx[1]));
    uart_msg_streamer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSG_LEN(1), .MSG("A"),
        .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(GAP)) u2 (.clk(clk), .rst(rst[2]),
        .start(start[2]), .periodic_en(per[2]), .abort(abort[2]), .uart_tx(tx[2]),
        .busy(busy[2]), .done(done[2]), .byte_idx(idx[2]));
    uart_msg_streamer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSG_LEN(2), .MSG("AB"),
        .PARITY(0), .STOP_BITS(2), .GAP_CYCLES(GAP)) u3 (.clk(clk), .rst(rst[3]),
        .start(start[3]), .periodic_en(per[3]), .abort(abort[3]), .uart_tx(tx[3]),
        .busy(busy[3]), .done(done[3]), .byte_idx(idx[3]));
    uart_msg_streamer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .MSG_LEN(1), .MSG("A"),
        .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(GAP)) u4 (.clk(clk), .rst(rst[4]),
        .start(start[4]), .periodic_en(per[4]), .abort(abort[4]), .uart_tx(tx[4]),
        .busy(busy[4]), .done(done[4]), .byte_idx(idx[4]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_len(input int k);
        return (k == 0 || k == 3) ? 2 : 1;
    endfunction

    function automatic int cfg_par(input int k);
        return (k == 1) ? 2 : (k == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_stop(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic logic [7:0] msg_byte(input int k, input int b);
        return (cfg_len(k) == 2 && b == 1) ? 8'h42 : 8'h41;
    endfunction

    function automatic int msg_cycles(input int k);
        return cfg_len(k) * (9 + ((cfg_par(k) != 0) ? 1 : 0) + cfg_stop(k)) * BAUD_DIV;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference line model: entry = {uart_tx, busy, done, byte_idx} for each cycle
    // after the start pulse; end_q records where each entry's frame ends (-1 in a gap).
    task automatic model_msg(input int k, input int reps);
        logic       bits[$];
        logic [7:0] b;
        int         base, fl, ones;
        logic       dn;
        full_q.delete();
        end_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int bi = 0; bi < cfg_len(k); bi++) begin
                b = msg_byte(k, bi);
                bits.delete();
                bits.push_back(1'b0);
                for (int j = 0; j < 8; j++) bits.push_back(b[j]);
                ones = $countones(b);
                if (cfg_par(k) == 2) bits.push_back((ones % 2) == 1);
                if (cfg_par(k) == 1) bits.push_back((ones % 2) == 0);
                for (int j = 0; j < cfg_stop(k); j++) bits.push_back(1'b1);
                base = full_q.size();
                fl = bits.size() * BAUD_DIV;
                for (int j = 0; j < bits.size(); j++) begin
                    for (int t = 0; t < BAUD_DIV; t++) begin
                        dn = (bi == cfg_len(k) - 1) && (j == bits.size() - 1) && (t == BAUD_DIV - 1);
                        full_q.push_back({bits[j], 1'b1, dn, bi[0]});
                        end_q.push_back(base + fl - 1);
                    end
                end
            end
            if (r < reps - 1) begin
                for (int t = 0; t < GAP; t++) begin
                    full_q.push_back(4'b1100);
                    end_q.push_back(-1);
                end
            end
        end
    endtask

    // driver: one start pulse, then cycle-by-cycle stimulus and comparison
    task automatic run(input int k, input int reps, input int abort_at, input int rst_at,
                       input bit noise);
        int         cut, ndone;
        logic [3:0] e, ent;
        model_msg(k, reps);
        cut = full_q.size();
        if (abort_at > 0) cut = (end_q[abort_at-1] < 0) ? abort_at : end_q[abort_at-1] + 1;
        if (rst_at > 0 && rst_at < cut) cut = rst_at;
        exp_q.delete();
        for (int i = 0; i < cut; i++) begin
            ent = full_q[i];
            if (abort_at > 0 && i == cut - 1) ent[1] = 1'b0;
            exp_q.push_back(ent);
        end
        repeat (3) exp_q.push_back(4'b1000);

        ndone = 0;
        @(negedge clk);
        start[k] = 1'b1;
        for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("line_d%0d_c%0d", k, c), {28'd0, tx[k], busy[k], done[k], idx[k]},
                  {28'd0, e});
            start[k] = noise && e[2] && ($urandom_range(0, 7) == 0);
            abort[k] = (c == abort_at);
            rst[k]   = (c == rst_at);
            if (e[1]) begin
                ndone++;
                per[k] = (ndone < reps);
            end else begin
                per[k] = 1'($urandom_range(0, 1));
            end
        end
        start[k] = 1'b0;
        abort[k] = 1'b0;
        rst[k]   = 1'b0;
        per[k]   = 1'b0;
    endtask

    initial begin
        int k, reps, mode, span;
        rst = 5'h1f;
        start = '0;
        per = '0;
        abort = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_d%0d", i), {28'd0, tx[i], busy[i], done[i], idx[i]}, 32'h8);
        end
        rst = '0;

        run(0, 1, 0, 0, 1'b1);                     // "AB": 200 cycles, done at 200
        run(1, 1, 0, 0, 1'b0);                     // even parity, 110-cycle frame
        run(2, 1, 0, 0, 1'b1);                     // odd parity
        run(3, 1, 0, 0, 1'b1);                     // two stop bits, back-to-back bytes
        run(4, 3, 0, 0, 1'b1);                     // periodic: restart at 151
        run(0, 1, 25, 0, 1'b0);                    // abort inside byte 0
        run(4, 3, $urandom_range(101, 150), 0, 1'b0);  // abort during the gap
        run(0, 1, 0, 45, 1'b1);                    // reset mid-frame
        run(0, 1, 0, 0, 1'b0);                     // resend from byte 0

        for (int it = 0; it < 10; it++) begin
            k = $urandom_range(0, 4);
            reps = $urandom_range(1, 2);
            mode = $urandom_range(0, 2);
            span = reps * msg_cycles(k) + (reps - 1) * GAP;
            case (mode)
                0:       run(k, reps, 0, 0, 1'b1);
                1:       run(k, reps, $urandom_range(1, span), 0, 1'b1);
                default: run(k, reps, 0, $urandom_range(1, span), 1'b1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_msg_streamer.md
UART_MSG_STREAMER -- requirements
Module: uart_msg_streamer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27000000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division, >= 2).
REQ-003 SHALL have parameter MSG_LEN, default 15: message length in bytes, range 1..256.
REQ-004 SHALL have parameter MSG, width MSG_LEN*8, default "Hello, world!\r\n": message bytes, first character in the MS byte.
REQ-005 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1: 1 or 2.
REQ-007 SHALL have parameter GAP_CYCLES, default 5000000: idle cycles between repeats in periodic mode, >= 1.
REQ-008 SHALL have the following ports; one clock, synchronous active-high reset:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a message when idle
- periodic_en  in  1  repeat the message after the gap
- abort  in  1  stop after the current frame
- uart_tx  out  1  serial line, idle high
- busy  out  1  high from the first start bit until return to IDLE
- done  out  1  one-cycle pulse after the last stop bit of a message
- byte_idx  out  max(1,$clog2(MSG_LEN))  index of the byte being sent

Function
REQ-009 SHALL implement states IDLE, START, DATA, PAR, STOP, GAP.
REQ-010 IDLE: start=1 at edge N -> START from cycle N+1, uart_tx=0, busy=1, byte_idx=0.
REQ-011 Bit timing: each START, DATA, PAR and STOP bit SHALL hold uart_tx for exactly BAUD_DIV cycles, using a baud counter that restarts at every bit.
REQ-012 DATA: 8 bits, LSB first; byte k = MSG[(MSG_LEN-1-k)*8 +: 8], so byte 0 is the first character.
REQ-013 PAR: entered only if PARITY != 0; bit = ^byte for even, ~^byte for odd.
REQ-014 STOP: uart_tx=1 for STOP_BITS*BAUD_DIV cycles.
REQ-015 Bytes SHALL be back-to-back: the start bit of byte k+1 follows the last stop cycle of byte k with no idle cycles.
REQ-016 Last byte (byte_idx = MSG_LEN-1) stop complete:
- done=1 for one cycle.
- periodic_en sampled that cycle: 1 -> GAP; 0 -> IDLE.
REQ-017 GAP: uart_tx=1, busy=1 for GAP_CYCLES cycles, then START with byte_idx=0.
REQ-018 A start pulse while busy=1 SHALL be ignored, with no queuing.
REQ-019 abort=1 at any cycle while busy SHALL latch an abort request:
- The current frame completes, including stop bits.
- Then -> IDLE, done stays 0, and the latch clears.
- abort during GAP -> IDLE on the next cycle.
REQ-020 Frame length SHALL be (1+8+(PARITY!=0)+STOP_BITS)*BAUD_DIV cycles.
REQ-021 uart_tx SHALL be driven from a register (glitch-free).

Reset
REQ-022 rst=1 at edge SHALL force next cycle:
- state IDLE, uart_tx=1, busy=0, done=0, byte_idx=0
- baud counter, gap counter and abort latch cleared
REQ-023 rst mid-frame SHALL truncate the frame: line high the next cycle, with no partial stop-bit completion.
REQ-024 rst SHALL take priority over start, abort and periodic_en in the same cycle.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000 -> BAUD_DIV=10)
REQ-025 MSG="AB", MSG_LEN=2, PARITY=0, STOP_BITS=1, start pulse:
- Line reads 0x41 then 0x42 in 200 cycles total.
- done pulses once at cycle 200; busy falls at cycle 201.
REQ-026 MSG="A", PARITY=2 then PARITY=1: frame 110 cycles; parity bit 0 (even) and 1 (odd) for 0x41.
REQ-027 STOP_BITS=2, MSG_LEN=2: the first stop period lasts 20 cycles high, and the next start bit follows at once.
REQ-028 periodic_en=1, GAP_CYCLES=50, MSG="A":
- done at cycle 100.
- Next start bit at cycle 151.
- Repeats continuously until periodic_en=0 at a message end.
REQ-029 Control and reset cases:
- abort asserted at cycle 25 of "AB": byte 0 completes, byte 1 is never sent, done never pulses.
- start pulsed mid-message: no effect.
REQ-030 rst asserted at cycle 45 of a frame: next cycle uart_tx=1, busy=0, byte_idx=0; a new start sends byte 0 again.
